// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: branch-table entry, branch prediction queue entry,
// and the branch resolve unit state encoding.
package cpu_types_pkg;

  localparam int unsigned BPQ_DEPTH = 4;

  typedef struct packed {
    logic [27:0] tag;
    logic [31:0] target;
    logic        valid;
  } branchentry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bpq_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bru_state_t;

  function automatic logic [31:0] bru_redirect(input logic        taken,
                                               input logic [31:0] pc,
                                               input logic [31:0] target);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/bp_queue.sv
// In-order FIFO of outstanding branch predictions; clear dominates push/pop.
module bp_queue
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = BPQ_DEPTH
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_clear,
  input  bpq_entry_t i_wdata,
  output bpq_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  bpq_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  // A pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge CLK) begin
    if (RST || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves the oldest predicted branch, raises flush/redirect and branch-table update.
// Optional resolution statistics counters under `BRANCH_STATS_EN.
module branch_resolve_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = BPQ_DEPTH
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pred_push,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        pred_full,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic        upd_wen,
  output logic [1:0]  upd_idx,
  output logic [27:0] upd_tag,
  output logic [31:0] upd_target,
  output logic        upd_valid,
  output logic        res_err,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  bru_state_t   r_state;
  bru_state_t   w_state_nxt;
  logic         w_res;
  logic         w_push_ok;
  logic         w_err;
  logic         w_head_taken;
  logic         w_mp;
  logic         w_upd_wen;
  bpq_entry_t   w_head;
  bpq_entry_t   w_wdata;
  logic         w_q_empty;
  branchentry_t w_upd;

  logic         r_mispredict;
  logic [31:0]  r_redirect_pc;
  logic         r_upd_wen;
  logic [1:0]   r_upd_idx;
  branchentry_t r_upd;
  logic         r_res_err;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_mp) w_state_nxt = RECOVER;
      RECOVER: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_res     = (r_state == RUN) && res_valid;
    w_push_ok = (r_state == RUN) && pred_push;
  end

  // A missing or mismatched head is handled as a not-taken prediction.
  always_comb begin
    w_err        = w_q_empty || (res_pc != w_head.pc);
    w_head_taken = !w_err && w_head.taken;
    w_mp         = w_res && (w_err || (w_head_taken != res_taken) ||
                   (w_head_taken && res_taken && (w_head.target != res_target)));
    w_upd_wen    = w_res && (res_taken || w_head_taken);
    w_upd        = '{tag: res_pc[31:4], target: res_target, valid: res_taken};
    w_wdata      = '{pc: pred_pc, taken: pred_taken, target: pred_target};
  end

  bp_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push_ok),
    .i_pop   (w_res),
    .i_clear (w_mp),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_full  (pred_full),
    .o_empty (w_q_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
      r_upd_wen     <= 1'b0;
      r_upd_idx     <= '0;
      r_upd         <= '0;
      r_res_err     <= 1'b0;
    end else begin
      r_mispredict  <= w_mp;
      r_redirect_pc <= w_mp ? bru_redirect(res_taken, res_pc, res_target) : '0;
      r_upd_wen     <= w_upd_wen;
      r_upd_idx     <= w_upd_wen ? res_pc[3:2] : '0;
      r_upd         <= w_upd_wen ? w_upd : '0;
      r_res_err     <= w_res && w_err;
    end
  end

  assign mispredict  = r_mispredict;
  assign redirect_pc = r_redirect_pc;
  assign upd_wen     = r_upd_wen;
  assign upd_idx     = r_upd_idx;
  assign upd_tag     = r_upd.tag;
  assign upd_target  = r_upd.target;
  assign upd_valid   = r_upd.valid;
  assign res_err     = r_res_err;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_mp_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else begin
      if (w_res && (r_br_count != '1)) r_br_count <= r_br_count + 32'd1;
      if (w_mp && (r_mp_count != '1))  r_mp_count <= r_mp_count + 32'd1;
    end
  end

  assign br_count = r_br_count;
  assign mp_count = r_mp_count;
`else
  assign br_count = '0;
  assign mp_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference queue model predicts each
// registered resolution result, checked one cycle after the stimulus edge.
module tb_branch_resolve_unit;
  import cpu_types_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pred_push, pred_taken, res_valid, res_taken;
  logic [31:0] pred_pc, pred_target, res_pc, res_target;
  logic        pred_full, mispredict, upd_wen, upd_valid, res_err;
  logic [31:0] redirect_pc, upd_target, br_count, mp_count;
  logic [1:0]  upd_idx;
  logic [27:0] upd_tag;

  always #5 CLK = ~CLK;

  branch_resolve_unit #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .pred_push(pred_push), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_full(pred_full),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .upd_wen(upd_wen), .upd_idx(upd_idx), .upd_tag(upd_tag),
    .upd_target(upd_target), .upd_valid(upd_valid), .res_err(res_err),
    .br_count(br_count), .mp_count(mp_count)
  );

  typedef struct packed {
    logic        mp;
    logic [31:0] rpc;
    logic        wen;
    logic [1:0]  idx;
    logic [27:0] tag;
    logic [31:0] tgt;
    logic        valid;
    logic        err;
  } res_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  typedef struct {
    bit          push;
    logic [31:0] ppc;
    bit          pt;
    logic [31:0] ptg;
    bit          rv;
    logic [31:0] rpc;
    bit          rt;
    logic [31:0] rtg;
  } stim_t;

  pred_t       mq[$];
  res_t        sb[$];
  bit          m_recover;
  int unsigned m_br, m_mp;
  int          tests, fails;

  function automatic stim_t P(input logic [31:0] pc, input bit t, input logic [31:0] tg);
    stim_t s = '{1'b1, pc, t, tg, 1'b0, 32'h0, 1'b0, 32'h0};
    return s;
  endfunction
  function automatic stim_t R(input logic [31:0] pc, input bit t, input logic [31:0] tg);
    stim_t s = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, t, tg};
    return s;
  endfunction
  function automatic stim_t PR(input logic [31:0] ppc, input logic [31:0] rpc);
    stim_t s = '{1'b1, ppc, 1'b0, 32'h0, 1'b1, rpc, 1'b0, 32'h0};
    return s;
  endfunction
  function automatic stim_t I();
    stim_t s = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    return s;
  endfunction

  // Observed result; redirect and update payload only matter while their strobe is high.
  function automatic res_t dut_res();
    res_t r = '0;
    r.mp  = mispredict;
    r.err = res_err;
    r.wen = upd_wen;
    if (mispredict) r.rpc = redirect_pc;
    if (upd_wen) begin
      r.idx = upd_idx; r.tag = upd_tag; r.tgt = upd_target; r.valid = upd_valid;
    end
    return r;
  endfunction

  task automatic cyc(input stim_t s);
    res_t e;
    bit   err, hpt, mp, pop, push_ok;
    e   = '0;
    mp  = 1'b0;
    pop = s.rv && !m_recover;
    if (pop) begin
      err = (mq.size() == 0) || (mq[0].pc != s.rpc);
      hpt = err ? 1'b0 : mq[0].taken;
      mp  = err || (hpt != s.rt) || (hpt && s.rt && (mq[0].target != s.rtg));
      e.mp  = mp;
      e.err = err;
      if (mp) e.rpc = s.rt ? s.rtg : s.rpc + 32'd4;
      e.wen = s.rt || hpt;
      if (e.wen) begin
        e.idx = s.rpc[3:2]; e.tag = s.rpc[31:4]; e.tgt = s.rtg; e.valid = s.rt;
      end
      sb.push_back(e);
      m_br++;
      if (mp) m_mp++;
    end
    push_ok = s.push && !m_recover && ((mq.size() < DEPTH) || (pop && mq.size() > 0));
    if (pop && mq.size() > 0) mq.delete(0);
    if (push_ok) mq.push_back('{s.ppc, s.pt, s.ptg});
    if (mp) mq.delete();
    m_recover = mp;
    pred_push = s.push; pred_pc = s.ppc; pred_taken = s.pt; pred_target = s.ptg;
    res_valid = s.rv;   res_pc = s.rpc;  res_taken = s.rt;  res_target = s.rtg;
    @(posedge CLK);
    #1;
    pred_push = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    mq.delete(); sb.delete(); m_recover = 1'b0; m_br = 0; m_mp = 0;
    tests++;
    if ({pred_full, mispredict, redirect_pc, upd_wen, upd_idx, upd_tag, upd_target,
         upd_valid, res_err, br_count, mp_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got full=%b mp=%b rpc=%h wen=%b err=%b br=%0d mpc=%0d required all 0",
               pred_full, mispredict, redirect_pc, upd_wen, res_err, br_count, mp_count);
    end
  endtask

  task automatic test_correct_nt();
    res_t  e;
    stim_t st[4] = '{P(32'h100, 0, 0), R(32'h100, 0, 0), R(32'h100, 0, 0), I()};
    foreach (st[i]) begin
      cyc(st[i]);
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      tests++;
      if ({dut_res(), pred_full} !== {e, mq.size() == DEPTH}) begin
        fails++;
        $display("FAIL correct_nt step %0d got %h/%b required %h/%b", i, dut_res(), pred_full,
                 e, mq.size() == DEPTH);
      end
      if (i == 1) begin
        tests++;
        if ({mispredict, upd_wen, res_err} !== 3'b000) begin
          fails++;
          $display("FAIL correct_nt_nowrite got mp=%b wen=%b err=%b required 0 0 0",
                   mispredict, upd_wen, res_err);
        end
      end
    end
  endtask

  task automatic test_direction();
    res_t  e;
    stim_t st[3] = '{P(32'h200, 0, 0), R(32'h200, 1, 32'h240), I()};
    foreach (st[i]) begin
      cyc(st[i]);
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      tests++;
      if ({dut_res(), pred_full} !== {e, mq.size() == DEPTH}) begin
        fails++;
        $display("FAIL direction step %0d got %h/%b required %h/%b", i, dut_res(), pred_full,
                 e, mq.size() == DEPTH);
      end
      if (i == 1) begin
        tests++;
        if ({mispredict, redirect_pc, upd_wen, upd_idx, upd_tag, upd_valid} !==
            {1'b1, 32'h240, 1'b1, 2'd0, 28'h20, 1'b1}) begin
          fails++;
          $display("FAIL direction_fields got mp=%b rpc=%h wen=%b idx=%0d tag=%h v=%b required 1 240 1 0 20 1",
                   mispredict, redirect_pc, upd_wen, upd_idx, upd_tag, upd_valid);
        end
      end
    end
  endtask

  task automatic test_recover();
    res_t  e;
    stim_t st[7] = '{P(32'h104, 1, 32'h300), P(32'h108, 0, 0), P(32'h10C, 0, 0),
                     R(32'h104, 1, 32'h308), '{1'b1, 32'h110, 1'b0, 32'h0, 1'b1, 32'h108, 1'b0, 32'h0},
                     R(32'h110, 0, 0), I()};
    foreach (st[i]) begin
      cyc(st[i]);
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      tests++;
      if ({dut_res(), pred_full} !== {e, mq.size() == DEPTH}) begin
        fails++;
        $display("FAIL recover step %0d got %h/%b required %h/%b", i, dut_res(), pred_full,
                 e, mq.size() == DEPTH);
      end
      if (i == 3) begin
        tests++;
        if ({mispredict, redirect_pc, upd_wen} !== {1'b1, 32'h308, 1'b1}) begin
          fails++;
          $display("FAIL recover_target got mp=%b rpc=%h wen=%b required 1 308 1",
                   mispredict, redirect_pc, upd_wen);
        end
      end
      if (i == 5) begin
        tests++;
        if ({res_err, redirect_pc} !== {1'b1, 32'h114}) begin
          fails++;
          $display("FAIL recover_push_dropped got err=%b rpc=%h required 1 114", res_err, redirect_pc);
        end
      end
    end
  endtask

  task automatic test_full();
    res_t  e;
    stim_t st[10] = '{P(32'h500, 0, 0), P(32'h504, 0, 0), P(32'h508, 0, 0), P(32'h50C, 0, 0),
                      P(32'h510, 0, 0), PR(32'h514, 32'h500),
                      R(32'h504, 0, 0), R(32'h508, 0, 0), R(32'h50C, 0, 0), R(32'h514, 0, 0)};
    foreach (st[i]) begin
      cyc(st[i]);
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      tests++;
      if ({dut_res(), pred_full} !== {e, mq.size() == DEPTH}) begin
        fails++;
        $display("FAIL full step %0d got %h/%b required %h/%b", i, dut_res(), pred_full,
                 e, mq.size() == DEPTH);
      end
      if (i == 3 || i == 5) begin
        tests++;
        if (pred_full !== 1'b1) begin
          fails++;
          $display("FAIL full_flag step %0d got %b required 1", i, pred_full);
        end
      end
    end
  endtask

  task automatic test_error();
    res_t  e;
    stim_t st[5] = '{R(32'h400, 0, 0), I(), P(32'h600, 1, 32'h700), R(32'h604, 1, 32'h800), I()};
    foreach (st[i]) begin
      cyc(st[i]);
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      tests++;
      if ({dut_res(), pred_full} !== {e, mq.size() == DEPTH}) begin
        fails++;
        $display("FAIL error step %0d got %h/%b required %h/%b", i, dut_res(), pred_full,
                 e, mq.size() == DEPTH);
      end
      if (i == 0) begin
        tests++;
        if ({res_err, mispredict, redirect_pc, upd_wen} !== {1'b1, 1'b1, 32'h404, 1'b0}) begin
          fails++;
          $display("FAIL error_empty got err=%b mp=%b rpc=%h wen=%b required 1 1 404 0",
                   res_err, mispredict, redirect_pc, upd_wen);
        end
      end
    end
  endtask

  task automatic test_reset_stats();
    res_t        e;
    logic [31:0] exp_br, exp_mp;
    stim_t st[7] = '{P(32'h10, 0, 0), P(32'h14, 0, 0), P(32'h18, 1, 32'h40),
                     R(32'h10, 0, 0), R(32'h14, 0, 0), R(32'h18, 1, 32'h44), I()};
    stim_t post[2] = '{R(32'h20, 0, 0), I()};
    foreach (st[i]) begin
      cyc(st[i]);
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      tests++;
      if ({dut_res(), pred_full} !== {e, mq.size() == DEPTH}) begin
        fails++;
        $display("FAIL stats step %0d got %h/%b required %h/%b", i, dut_res(), pred_full,
                 e, mq.size() == DEPTH);
      end
    end
`ifdef BRANCH_STATS_EN
    exp_br = m_br; exp_mp = m_mp;
`else
    exp_br = 0; exp_mp = 0;
`endif
    tests++;
    if ({br_count, mp_count} !== {exp_br, exp_mp}) begin
      fails++;
      $display("FAIL stats_counts got br=%0d mp=%0d required br=%0d mp=%0d",
               br_count, mp_count, exp_br, exp_mp);
    end
    for (int k = 0; k < 3; k++) cyc(P(32'h20 + 32'(4 * k), 0, 0));
    RST = 1'b1; res_valid = 1'b1; res_pc = 32'h20; res_taken = 1'b1; res_target = 32'h99;
    @(posedge CLK);
    #1;
    RST = 1'b0; res_valid = 1'b0;
    mq.delete(); sb.delete(); m_recover = 1'b0; m_br = 0; m_mp = 0;
    tests++;
    if ({pred_full, mispredict, redirect_pc, upd_wen, res_err, br_count, mp_count} !== '0) begin
      fails++;
      $display("FAIL midreset got full=%b mp=%b rpc=%h wen=%b err=%b br=%0d mpc=%0d required all 0",
               pred_full, mispredict, redirect_pc, upd_wen, res_err, br_count, mp_count);
    end
    foreach (post[i]) begin
      cyc(post[i]);
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      tests++;
      if ({dut_res(), pred_full} !== {e, mq.size() == DEPTH}) begin
        fails++;
        $display("FAIL midreset_empty step %0d got %h/%b required %h/%b", i, dut_res(), pred_full,
                 e, mq.size() == DEPTH);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    RST = 1'b1;
    pred_push = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    test_reset();
    test_correct_nt();
    test_direction();
    test_recover();
    test_full();
    test_error();
    test_reset_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
